// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator: next-PC source codes and FSM states.
package pc_gen_pkg;

    localparam int unsigned PC_SEL_W = 2;

    localparam logic [PC_SEL_W-1:0] PC_SEL_SEQ   = 2'b00;
    localparam logic [PC_SEL_W-1:0] PC_SEL_ALU   = 2'b01;
    localparam logic [PC_SEL_W-1:0] PC_SEL_ADDER = 2'b10;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10
    } pc_state_e;

endpackage

// File: rtl/pc_gen_target_mux.sv
// Next-PC target select with misalignment check on redirect sources.
// PC_GEN_RVC_EN relaxes alignment to 2-byte boundaries.
module pc_gen_target_mux
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [PC_SEL_W-1:0] pc_sel,
    input  logic [XLEN-1:0]     pc_next,
    input  logic [XLEN-1:0]     alu_result,
    input  logic [XLEN-1:0]     pc_adder_result,
    output logic [XLEN-1:0]     target_c,
    output logic                misaligned_c
);

    logic redirect;
    logic unused_alu_lsb;

    // JALR targets always have bit 0 cleared before use
    assign unused_alu_lsb = alu_result[0];

    always_comb begin
        target_c = pc_next;
        redirect = 1'b0;
        unique case (pc_sel)
            PC_SEL_ALU: begin
                target_c = {alu_result[XLEN-1:1], 1'b0};
                redirect = 1'b1;
            end
            PC_SEL_ADDER: begin
                target_c = pc_adder_result;
                redirect = 1'b1;
            end
            default: begin
                target_c = pc_next;
                redirect = 1'b0;
            end
        endcase
    end

`ifdef PC_GEN_RVC_EN
    assign misaligned_c = redirect && target_c[0];
`else
    assign misaligned_c = redirect && (target_c[1:0] != 2'b00);
`endif

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential/redirect fetch address with misaligned-target trap.
// Optional compressed-instruction support via PC_GEN_RVC_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned    XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PC_SEL_W-1:0] pc_sel,
    input  logic [XLEN-1:0]     alu_result,
    input  logic [XLEN-1:0]     pc_adder_result,
    input  logic                is_compressed,
    input  logic                fetch_ready,
    input  logic                trap_ack,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_next,
    output logic                fetch_valid,
    output logic                trap_pending,
    output logic [XLEN-1:0]     trap_addr
);

    pc_state_e       state;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            advance;

    // Sequential successor, wrapping modulo 2^XLEN
`ifdef PC_GEN_RVC_EN
    assign pc_next = pc + (is_compressed ? XLEN'(2) : XLEN'(4));
`else
    logic unused_is_compressed;
    assign unused_is_compressed = is_compressed;
    assign pc_next = pc + XLEN'(4);
`endif

    assign fetch_valid = (state == ST_RUN) && en;
    assign advance     = fetch_valid && fetch_ready;

    pc_gen_target_mux #(
        .XLEN (XLEN)
    ) u_target_mux (
        .pc_sel          (pc_sel),
        .pc_next         (pc_next),
        .alu_result      (alu_result),
        .pc_adder_result (pc_adder_result),
        .target_c        (target),
        .misaligned_c    (misaligned)
    );

    // Control FSM; a misaligned redirect parks the PC and waits for the trap handler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_BOOT;
            pc           <= RESET_VECTOR;
            trap_pending <= 1'b0;
            trap_addr    <= '0;
        end else begin
            unique case (state)
                ST_BOOT: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (advance) begin
                        if (misaligned) begin
                            trap_addr    <= target;
                            trap_pending <= 1'b1;
                            state        <= ST_TRAP;
                        end else begin
                            pc <= target;
                        end
                    end
                end
                ST_TRAP: begin
                    if (trap_ack) begin
                        pc           <= TRAP_VECTOR;
                        trap_pending <= 1'b0;
                        state        <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (RESET_VECTOR = 0x80); adapts to PC_GEN_RVC_EN.
module tb_pc_gen;
    import pc_gen_pkg::*;

    localparam int unsigned XLEN = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic [PC_SEL_W-1:0] pc_sel;
    logic [XLEN-1:0]     alu_result;
    logic [XLEN-1:0]     pc_adder_result;
    logic                is_compressed;
    logic                fetch_ready;
    logic                trap_ack;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     pc_next;
    logic                fetch_valid;
    logic                trap_pending;
    logic [XLEN-1:0]     trap_addr;

    int n_checks = 0;
    int n_fail   = 0;

    pc_gen #(
        .XLEN         (XLEN),
        .RESET_VECTOR (32'h0000_0080),
        .TRAP_VECTOR  (32'h0000_0100)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .pc_sel          (pc_sel),
        .alu_result      (alu_result),
        .pc_adder_result (pc_adder_result),
        .is_compressed   (is_compressed),
        .fetch_ready     (fetch_ready),
        .trap_ack        (trap_ack),
        .pc              (pc),
        .pc_next         (pc_next),
        .fetch_valid     (fetch_valid),
        .trap_pending    (trap_pending),
        .trap_addr       (trap_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_adder(input logic [31:0] t);
        pc_sel          = PC_SEL_ADDER;
        pc_adder_result = t;
        step();
        pc_sel          = PC_SEL_SEQ;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        en              = 1'b1;
        pc_sel          = PC_SEL_SEQ;
        alu_result      = '0;
        pc_adder_result = '0;
        is_compressed   = 1'b0;
        fetch_ready     = 1'b1;
        trap_ack        = 1'b0;

        // Reset values
        step(); step();
        check("rst_pc", pc, 32'h80);
        check("rst_fv", 32'(fetch_valid), 32'h0);
        check("rst_tp", 32'(trap_pending), 32'h0);
        check("rst_ta", trap_addr, 32'h0);

        // BOOT cycle then sequential fetch
        rst_n = 1'b1;
        check("boot_fv", 32'(fetch_valid), 32'h0);
        step();
        check("run_fv", 32'(fetch_valid), 32'h1);
        check("run_pc0", pc, 32'h80);
        step();
        check("seq_pc1", pc, 32'h84);
        step();
        check("seq_pc2", pc, 32'h88);
        check("pc_next", pc_next, 32'h8c);

        // Redirects: adder then ALU with bit 0 cleared
        redirect_adder(32'h200);
        check("adder_pc", pc, 32'h200);
        pc_sel     = PC_SEL_ALU;
        alu_result = 32'h301;
        step();
        pc_sel     = PC_SEL_SEQ;
        check("alu_pc", pc, 32'h300);

        // Stall on fetch_ready low; targets ignored without advance
        redirect_adder(32'h40);
        check("stall_start", pc, 32'h40);
        fetch_ready     = 1'b0;
        pc_sel          = PC_SEL_ADDER;
        pc_adder_result = 32'h999;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 32'h40);
            check("stall_fv", 32'(fetch_valid), 32'h1);
        end
        fetch_ready = 1'b1;
        pc_sel      = PC_SEL_SEQ;
        step();
        check("stall_release", pc, 32'h44);

        // en low freezes PC and drops fetch_valid
        en = 1'b0;
        #1;
        check("en_low_fv", 32'(fetch_valid), 32'h0);
        step();
        check("en_low_pc", pc, 32'h44);
        en = 1'b1;

        // Misaligned redirect traps, pc held; ack (with en low) goes to trap vector
`ifdef PC_GEN_RVC_EN
        redirect_adder(32'h103);
        check("trap_addr", trap_addr, 32'h103);
`else
        redirect_adder(32'h102);
        check("trap_addr", trap_addr, 32'h102);
`endif
        check("trap_pend", 32'(trap_pending), 32'h1);
        check("trap_fv", 32'(fetch_valid), 32'h0);
        check("trap_pc_hold", pc, 32'h44);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("trap_wait", 32'(trap_pending), 32'h1);
        end
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        check("ack_pc", pc, 32'h100);
        check("ack_tp", 32'(trap_pending), 32'h0);
        en = 1'b1;
        #1;
        check("ack_fv", 32'(fetch_valid), 32'h1);
        step();
        check("resume_pc", pc, 32'h104);

        // trap_ack outside TRAP is ignored
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        check("ack_ignored", pc, 32'h108);

        // Compressed step and alignment boundary
        redirect_adder(32'h10);
        is_compressed = 1'b1;
        step();
        is_compressed = 1'b0;
`ifdef PC_GEN_RVC_EN
        check("rvc_step", pc, 32'h12);
        redirect_adder(32'h102);
        check("rvc_accept", pc, 32'h102);
        check("rvc_no_trap", 32'(trap_pending), 32'h0);
`else
        check("rvc_ignored", pc, 32'h14);
        pc_sel     = PC_SEL_ALU;
        alu_result = 32'h303;
        step();
        pc_sel     = PC_SEL_SEQ;
        check("alu_mis_tp", 32'(trap_pending), 32'h1);
        check("alu_mis_ta", trap_addr, 32'h302);
        check("alu_mis_pc", pc, 32'h14);
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        check("alu_mis_ack", pc, 32'h100);
`endif

        // Wrap-around from the top of the address space
        redirect_adder(32'hFFFF_FFFC);
        check("wrap_top", pc, 32'hFFFF_FFFC);
        step();
        check("wrap_zero", pc, 32'h0);

        // Asynchronous reset while in TRAP
        redirect_adder(32'h203);
        check("pre_rst_tp", 32'(trap_pending), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_tp", 32'(trap_pending), 32'h0);
        check("async_pc", pc, 32'h80);
        check("async_ta", trap_addr, 32'h0);
        check("async_fv", 32'(fetch_valid), 32'h0);
        step();
        rst_n = 1'b1;
        check("reboot_fv0", 32'(fetch_valid), 32'h0);
        step();
        check("reboot_fv1", 32'(fetch_valid), 32'h1);
        check("reboot_pc0", pc, 32'h80);
        step();
        check("reboot_pc1", pc, 32'h84);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RV32 core, successor to the single-width PC register. It holds the fetch address, advances sequentially or redirects to an ALU or PC-adder target, and presents the address to instruction memory over a valid/ready handshake. Misaligned redirect targets are caught and turned into a trap sequence rather than being fetched. It sits between the branch/jump datapath (ALU, PC adder) and the instruction-fetch port.

## Interface
- XLEN, 32: address width, ≥ 16.
- RESET_VECTOR, 0: PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100: PC value loaded when a trap is acknowledged.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  pipeline enable; low freezes PC and deasserts fetch_valid.
- pc_sel  in  2  next-PC source: PC_SEL_SEQ, PC_SEL_ALU, PC_SEL_ADDER (code 3 = SEQ).
- alu_result  in  XLEN  JALR target; bit 0 forced to 0 before use.
- pc_adder_result  in  XLEN  branch/JAL target (PC + imm).
- is_compressed  in  1  current instruction is 16-bit (used only with PC_GEN_RVC_EN).
- fetch_ready  in  1  instruction memory accepts the address.
- trap_ack  in  1  trap handler acknowledges a pending trap.
- pc  out  XLEN  current fetch address, registered.
- pc_next  out  XLEN  sequential successor (pc + 4, or + 2 when compressed), combinational.
- fetch_valid  out  1  pc is a valid fetch request.
- trap_pending  out  1  misaligned-target trap waiting for acknowledge.
- trap_addr  out  XLEN  offending target address, registered.

## Operation
- FSM states:
  - BOOT: single cycle after reset, then RUN.
  - RUN: normal fetch.
  - TRAP: wait for trap_ack.
- fetch_valid = (state == RUN) && en.
- Advance condition: fetch_valid && fetch_ready.
- On advance, the target is selected by pc_sel:
  - SEQ → pc_next.
  - ALU → {alu_result[XLEN-1:1], 1'b0}.
  - ADDER → pc_adder_result.
  - SEQ targets are never checked for misalignment.
- A redirect target with target[1:0] != 0 is misaligned. It is not loaded; instead:
  - trap_addr ← target.
  - trap_pending ← 1.
  - state ← TRAP.
  - pc holds its value.
- In TRAP, fetch_valid = 0. When trap_ack = 1: pc ← TRAP_VECTOR, trap_pending ← 0, state ← RUN. This happens regardless of en.
- trap_ack outside TRAP is ignored. pc_sel and the targets are ignored when no advance occurs.
- Arithmetic wraps modulo 2^XLEN: pc = all-ones minus 3 advances to 0, with no flag.

## Timing
- Reset values: pc = RESET_VECTOR, state = BOOT, fetch_valid = 0, trap_pending = 0, trap_addr = 0.
- First fetch_valid occurs in the second cycle after rst_n deasserts (one BOOT cycle).
- Redirect latency: the new pc is visible the cycle after the advance edge.
- Trap latency: trap_pending is set the cycle after the offending advance. pc = TRAP_VECTOR the cycle after trap_ack is sampled.
- fetch_ready low: pc, fetch_valid and the address are held stable until accepted.
- en low during RUN: no advance; pc is held.
- Reset asserted mid-trap or mid-stall: all state returns to reset values immediately.

## Configuration
- PC_GEN_RVC_EN, defined (compressed-instruction support):
  - pc_next = pc + (is_compressed ? 2 : 4).
  - Misaligned means target[0] != 0; for the ALU source this never occurs because bit 0 is cleared.
- PC_GEN_RVC_EN, undefined:
  - is_compressed is ignored.
  - pc_next = pc + 4.
  - Misaligned means target[1:0] != 0.

## Structure
- Shared package pc_gen_pkg holds:
  - PC_SEL_SEQ = 2'b00, PC_SEL_ALU = 2'b01, PC_SEL_ADDER = 2'b10.
  - State encodings BOOT/RUN/TRAP.
- Sub-module pc_gen_target_mux: combinational target select plus misalignment check, so the check logic can be reused by the decoder.

## Test plan
- Release reset with RESET_VECTOR = 0x80 and fetch_ready held 1 → BOOT cycle with fetch_valid = 0, then pc = 0x80, 0x84, 0x88 on successive cycles.
- pc_sel = ADDER with pc_adder_result = 0x200 on an advance → next pc = 0x200. Then pc_sel = ALU with alu_result = 0x301 → next pc = 0x300.
- fetch_ready low for 3 cycles at pc = 0x40 → pc holds 0x40 and fetch_valid stays 1; one cycle after ready rises, pc = 0x44.
- pc_sel = ADDER with target 0x102 (RVC off) → trap_pending = 1, trap_addr = 0x102, fetch_valid = 0, pc unchanged. trap_ack after 4 cycles → pc = 0x100, fetch resumes.
- With PC_GEN_RVC_EN defined: is_compressed = 1 at pc = 0x10 → 0x12. Target 0x102 is accepted; target 0x103 traps.
- rst_n pulsed low while in TRAP → trap_pending = 0, pc = RESET_VECTOR asynchronously, then the BOOT sequence repeats.
